sprite_motion_engine: RTL and testbench

//  Parametrised multi-sprite motion and address engine for the VGA seabed display.
//  - Holds position, direction, speed level and animation frame for N_SPR sprites.
//  - Advances every sprite once per frame_sync: edge bounce, row stepping and a "jump" (catch) lift.
//  - Per pixel, resolves which sprite covers (pixel_x, pixel_y) and outputs the sprite ROM

---
 rtl/sprite_motion_engine_if.sv | 28 ++
 rtl/sprite_motion_engine.sv | 155 +++++++++++++++
 tb/tb_sprite_motion_engine.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_motion_engine_if.sv
// Control/pixel bus between the display controller and the sprite motion engine.
interface sprite_motion_engine_if #(
    parameter int N_SPR = 3
);
    logic                  frame_sync;
    logic [N_SPR-1:0]      speed_up;
    logic [N_SPR-1:0]      jump;
    logic [9:0]            pixel_x;
    logic [9:0]            pixel_y;
    logic [N_SPR*10-1:0]   spr_x;
    logic [N_SPR*10-1:0]   spr_y;
    logic [N_SPR*2-1:0]    spr_dir;
    logic [N_SPR*3-1:0]    speed_lvl;
    logic [2:0]            anim_frame;
    logic                  hit_any;
    logic [1:0]            hit_id;
    logic [15:0]           rom_addr;

    modport master (
        output frame_sync, speed_up, jump, pixel_x, pixel_y,
        input  spr_x, spr_y, spr_dir, speed_lvl, anim_frame, hit_any, hit_id, rom_addr
    );

    modport slave (
        input  frame_sync, speed_up, jump, pixel_x, pixel_y,
        output spr_x, spr_y, spr_dir, speed_lvl, anim_frame, hit_any, hit_id, rom_addr
    );
endinterface

// File: rtl/sprite_motion_engine.sv
// Per-frame sprite motion (bounce, row step, jump lift), animation counter and
// registered per-pixel sprite ROM address lookup.
module sprite_motion_engine #(
    parameter int N_SPR     = 3,
    parameter int SPR_W     = 64,
    parameter int SPR_H     = 32,
    parameter int SCR_W     = 640,
    parameter int SCR_H     = 480,
    parameter int MAX_LVL   = 4,
    parameter int FRAMES    = 8,
    parameter int FRAME_DIV = 2,
    parameter int Y_STEP    = 1,
    parameter int JUMP      = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sprite_motion_engine_if.slave bus
);
    localparam int CNT_MAX = FRAME_DIV * FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [9:0]       x_q   [N_SPR];
    logic [9:0]       x_d   [N_SPR];
    logic [9:0]       y_q   [N_SPR];
    logic [9:0]       y_d   [N_SPR];
    logic [1:0]       dir_q [N_SPR];
    logic [1:0]       dir_d [N_SPR];
    logic [2:0]       lvl_q [N_SPR];
    logic [2:0]       lvl_d [N_SPR];
    logic [N_SPR-1:0] pend_q, pend_d, vstep;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       anim;
    logic             hit_any_q, hit_any_d;
    logic [1:0]       hit_id_q, hit_id_d;
    logic [15:0]      rom_addr_q, rom_addr_d;
    int               lx, ly;

    assign anim = 3'((int'(cnt_q) / FRAME_DIV) % FRAMES);

    always_comb begin
        cnt_d = cnt_q;
        if (bus.frame_sync)
            cnt_d = (int'(cnt_q) == CNT_MAX - 1) ? '0 : cnt_q + CNT_W'(1);
    end

    // A jump seen in the same cycle as frame_sync is folded into pend_d and taken now.
    always_comb begin
        pend_d = pend_q | bus.jump;
        vstep  = '0;
        for (int i = 0; i < N_SPR; i++) begin
            x_d[i]   = x_q[i];
            y_d[i]   = y_q[i];
            dir_d[i] = dir_q[i];
            lvl_d[i] = lvl_q[i];
            if (bus.speed_up[i])
                lvl_d[i] = (int'(lvl_q[i]) == MAX_LVL) ? 3'd0 : lvl_q[i] + 3'd1;
            if (bus.frame_sync && pend_d[i]) begin
                y_d[i]    = (int'(y_q[i]) >= JUMP) ? 10'(int'(y_q[i]) - JUMP) : 10'd0;
                pend_d[i] = 1'b0;
            end else if (bus.frame_sync && lvl_q[i] != 3'd0) begin
                if (!dir_q[i][0]) begin
                    if (int'(x_q[i]) + SPR_W - 1 + int'(lvl_q[i]) >= SCR_W - 1) begin
                        x_d[i]      = 10'(SCR_W - SPR_W);
                        dir_d[i][0] = 1'b1;
                        vstep[i]    = 1'b1;
                    end else begin
                        x_d[i] = x_q[i] + 10'(lvl_q[i]);
                    end
                end else begin
                    if (int'(x_q[i]) <= int'(lvl_q[i])) begin
                        x_d[i]      = 10'd0;
                        dir_d[i][0] = 1'b0;
                        vstep[i]    = 1'b1;
                    end else begin
                        x_d[i] = x_q[i] - 10'(lvl_q[i]);
                    end
                end
                if (vstep[i]) begin
                    if (!dir_q[i][1]) begin
                        if (int'(y_q[i]) + SPR_H - 1 + Y_STEP > SCR_H - 1) begin
                            y_d[i]      = 10'(SCR_H - SPR_H);
                            dir_d[i][1] = 1'b1;
                        end else begin
                            y_d[i] = 10'(int'(y_q[i]) + Y_STEP);
                        end
                    end else if (int'(y_q[i]) < Y_STEP) begin
                        y_d[i]      = 10'd0;
                        dir_d[i][1] = 1'b0;
                    end else begin
                        y_d[i] = 10'(int'(y_q[i]) - Y_STEP);
                    end
                end
            end
        end
    end

    // Scan from the highest index down so the lowest covering sprite is the one kept.
    always_comb begin
        hit_any_d  = 1'b0;
        hit_id_d   = '0;
        rom_addr_d = '0;
        lx         = 0;
        ly         = 0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (bus.pixel_x >= x_q[i] && int'(bus.pixel_x) <= int'(x_q[i]) + SPR_W - 1 &&
                bus.pixel_y >= y_q[i] && int'(bus.pixel_y) <= int'(y_q[i]) + SPR_H - 1) begin
                lx = int'(bus.pixel_x) - int'(x_q[i]);
                if (dir_q[i][0])
                    lx = SPR_W - 1 - lx;
                ly         = int'(bus.pixel_y) - int'(y_q[i]);
                hit_any_d  = 1'b1;
                hit_id_d   = 2'(i);
                rom_addr_d = 16'(int'(anim) * SPR_W * SPR_H + ly * SPR_W + lx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_SPR; i++) begin
                x_q[i]   <= '0;
                y_q[i]   <= 10'(SCR_H - SPR_H * (i + 1));
                dir_q[i] <= '0;
                lvl_q[i] <= 3'd1;
            end
            pend_q     <= '0;
            cnt_q      <= '0;
            hit_any_q  <= 1'b0;
            hit_id_q   <= '0;
            rom_addr_q <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            dir_q      <= dir_d;
            lvl_q      <= lvl_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            hit_any_q  <= hit_any_d;
            hit_id_q   <= hit_id_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    for (genvar g = 0; g < N_SPR; g++) begin : g_out
        assign bus.spr_x[10*g +: 10]    = x_q[g];
        assign bus.spr_y[10*g +: 10]    = y_q[g];
        assign bus.spr_dir[2*g +: 2]    = dir_q[g];
        assign bus.speed_lvl[3*g +: 3]  = lvl_q[g];
    end

    assign bus.anim_frame = anim;
    assign bus.hit_any    = hit_any_q;
    assign bus.hit_id     = hit_id_q;
    assign bus.rom_addr   = rom_addr_q;
endmodule

// File: tb/tb_sprite_motion_engine.sv
// Randomized and directed bench for sprite_motion_engine against a behavioural model.
module tb_sprite_motion_engine;
    logic clk = 1'b0;
    logic reset_n;

    sprite_motion_engine_if #(.N_SPR(3)) bus ();
    sprite_motion_engine #(.N_SPR(3)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mx[3], my[3], mdx[3], mdy[3], ml[3], mp[3], mc;
    int e_hit, e_id, e_addr;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mx[i] = 0; my[i] = 480 - 32 * (i + 1); mdx[i] = 0; mdy[i] = 0; ml[i] = 1; mp[i] = 0;
        end
        mc = 0;
    endtask

    task automatic model_step(input bit fs, input logic [2:0] su, input logic [2:0] jp);
        bit bounce;
        for (int i = 0; i < 3; i++) begin
            bounce = 1'b0;
            if (jp[i]) mp[i] = 1;
            if (fs && mp[i] != 0) begin
                my[i] = (my[i] >= 32) ? my[i] - 32 : 0;
                mp[i] = 0;
            end else if (fs && ml[i] > 0) begin
                if (mdx[i] == 0) begin
                    if (mx[i] + 63 + ml[i] >= 639) begin mx[i] = 576; mdx[i] = 1; bounce = 1; end
                    else mx[i] += ml[i];
                end else begin
                    if (mx[i] <= ml[i]) begin mx[i] = 0; mdx[i] = 0; bounce = 1; end
                    else mx[i] -= ml[i];
                end
                if (bounce) begin
                    if (mdy[i] == 0) begin
                        if (my[i] + 32 > 479) begin my[i] = 448; mdy[i] = 1; end else my[i] += 1;
                    end else begin
                        if (my[i] < 1) begin my[i] = 0; mdy[i] = 0; end else my[i] -= 1;
                    end
                end
            end
            if (su[i]) ml[i] = (ml[i] == 4) ? 0 : ml[i] + 1;
        end
        if (fs) mc = (mc + 1) % 16;
    endtask

    task automatic model_pixel(input int px, input int py);
        int lx;
        e_hit = 0; e_id = 0; e_addr = 0;
        for (int i = 0; i < 3; i++) begin
            if (e_hit == 0 && px >= mx[i] && px <= mx[i] + 63 && py >= my[i] && py <= my[i] + 31) begin
                lx = px - mx[i];
                if (mdx[i] != 0) lx = 63 - lx;
                e_hit = 1; e_id = i;
                e_addr = (((mc / 2) % 8) * 2048 + (py - my[i]) * 64 + lx) % 65536;
            end
        end
    endtask

    // One clock of stimulus; expected pixel result is taken from pre-edge model state.
    task automatic drive(input bit fs, input logic [2:0] su, input logic [2:0] jp, input int px, input int py);
        bus.frame_sync = fs; bus.speed_up = su; bus.jump = jp;
        bus.pixel_x = 10'(px); bus.pixel_y = 10'(py);
        model_pixel(px, py);
        @(posedge clk);
        model_step(fs, su, jp);
        #1;
        bus.frame_sync = 1'b0; bus.speed_up = '0; bus.jump = '0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        bus.frame_sync = 1'b0; bus.speed_up = '0; bus.jump = '0; bus.pixel_x = '0; bus.pixel_y = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.spr_x[10*i +: 10] !== 10'd0) begin errors++; $display("FAIL reset_x%0d got %0d want 0", i, bus.spr_x[10*i +: 10]); end
            checks++; if (bus.spr_y[10*i +: 10] !== 10'(480 - 32 * (i + 1))) begin errors++; $display("FAIL reset_y%0d got %0d want %0d", i, bus.spr_y[10*i +: 10], 480 - 32 * (i + 1)); end
            checks++; if (bus.spr_dir[2*i +: 2] !== 2'b00) begin errors++; $display("FAIL reset_dir%0d got %b want 00", i, bus.spr_dir[2*i +: 2]); end
            checks++; if (bus.speed_lvl[3*i +: 3] !== 3'd1) begin errors++; $display("FAIL reset_lvl%0d got %0d want 1", i, bus.speed_lvl[3*i +: 3]); end
        end
        checks++; if (bus.anim_frame !== 3'd0) begin errors++; $display("FAIL reset_anim got %0d want 0", bus.anim_frame); end
        checks++; if (bus.hit_any !== 1'b0) begin errors++; $display("FAIL reset_hit_any got %0d want 0", bus.hit_any); end
        checks++; if (bus.hit_id !== 2'd0) begin errors++; $display("FAIL reset_hit_id got %0d want 0", bus.hit_id); end
        checks++; if (bus.rom_addr !== 16'd0) begin errors++; $display("FAIL reset_rom_addr got %0d want 0", bus.rom_addr); end
    endtask

    task automatic test_bounce();
        apply_reset();
        repeat (575) drive(1'b1, 3'b000, 3'b000, 0, 0);
        checks++; if (bus.spr_x[9:0] !== 10'd575) begin errors++; $display("FAIL bounce_x575 got %0d want 575", bus.spr_x[9:0]); end
        checks++; if (bus.spr_dir[1:0] !== 2'b00) begin errors++; $display("FAIL bounce_dir575 got %b want 00", bus.spr_dir[1:0]); end
        drive(1'b1, 3'b000, 3'b000, 0, 0);
        checks++; if (bus.spr_x[9:0] !== 10'd576) begin errors++; $display("FAIL bounce_x576 got %0d want 576", bus.spr_x[9:0]); end
        checks++; if (bus.spr_y[9:0] !== 10'd448) begin errors++; $display("FAIL bounce_y576 got %0d want 448", bus.spr_y[9:0]); end
        checks++; if (bus.spr_dir[1:0] !== 2'b11) begin errors++; $display("FAIL bounce_dir576 got %b want 11", bus.spr_dir[1:0]); end
        for (int i = 1; i < 3; i++) begin
            checks++; if (bus.spr_x[10*i +: 10] !== 10'(mx[i])) begin errors++; $display("FAIL bounce_model_x%0d got %0d want %0d", i, bus.spr_x[10*i +: 10], mx[i]); end
            checks++; if (bus.spr_y[10*i +: 10] !== 10'(my[i])) begin errors++; $display("FAIL bounce_model_y%0d got %0d want %0d", i, bus.spr_y[10*i +: 10], my[i]); end
        end
    endtask

    task automatic test_mirror_anim();
        repeat (4) drive(1'b0, 3'b001, 3'b000, 0, 0);
        drive(1'b0, 3'b000, 3'b000, 581, 450);
        checks++; if (bus.hit_any !== 1'b1) begin errors++; $display("FAIL mirror_hit got %0d want 1", bus.hit_any); end
        checks++; if (bus.hit_id !== 2'd0) begin errors++; $display("FAIL mirror_id got %0d want 0", bus.hit_id); end
        checks++; if (bus.rom_addr !== 16'd186) begin errors++; $display("FAIL mirror_addr got %0d want 186", bus.rom_addr); end
        repeat (3) drive(1'b1, 3'b000, 3'b000, 0, 0);
        checks++; if (bus.anim_frame !== 3'd1) begin errors++; $display("FAIL anim_frame got %0d want 1", bus.anim_frame); end
        drive(1'b0, 3'b000, 3'b000, 581, 450);
        checks++; if (bus.rom_addr !== 16'd2234) begin errors++; $display("FAIL anim_addr got %0d want 2234", bus.rom_addr); end
        checks++; if (bus.rom_addr !== 16'(e_addr)) begin errors++; $display("FAIL anim_addr_model got %0d want %0d", bus.rom_addr, e_addr); end
    endtask

    task automatic test_address();
        apply_reset();
        drive(1'b0, 3'b000, 3'b000, 5, 450);
        checks++; if (bus.hit_any !== 1'b1) begin errors++; $display("FAIL addr_hit got %0d want 1", bus.hit_any); end
        checks++; if (bus.hit_id !== 2'd0) begin errors++; $display("FAIL addr_id got %0d want 0", bus.hit_id); end
        checks++; if (bus.rom_addr !== 16'd133) begin errors++; $display("FAIL addr_rom got %0d want 133", bus.rom_addr); end
        drive(1'b0, 3'b000, 3'b000, 200, 100);
        checks++; if (bus.hit_any !== 1'b0 || bus.rom_addr !== 16'd0) begin errors++; $display("FAIL addr_nohit got %0d/%0d want 0/0", bus.hit_any, bus.rom_addr); end
    endtask

    task automatic test_speed();
        int want_l[4] = '{2, 3, 4, 0};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 3'b010, 3'b000, 0, 0);
            checks++; if (bus.speed_lvl[5:3] !== 3'(want_l[k])) begin errors++; $display("FAIL speed_lvl step%0d got %0d want %0d", k, bus.speed_lvl[5:3], want_l[k]); end
        end
        repeat (100) drive(1'b1, 3'b000, 3'b000, 0, 0);
        checks++; if (bus.spr_x[19:10] !== 10'd0) begin errors++; $display("FAIL speed_stopped_x got %0d want 0", bus.spr_x[19:10]); end
        checks++; if (bus.spr_x[9:0] !== 10'd100) begin errors++; $display("FAIL speed_moving_x got %0d want 100", bus.spr_x[9:0]); end
        drive(1'b0, 3'b011, 3'b000, 0, 0);
        checks++; if (bus.speed_lvl[8:0] !== {3'd1, 3'd1, 3'd2}) begin errors++; $display("FAIL speed_multi got %h want %h", bus.speed_lvl[8:0], {3'd1, 3'd1, 3'd2}); end
    endtask

    task automatic test_jump();
        apply_reset();
        drive(1'b0, 3'b000, 3'b001, 0, 0);
        drive(1'b1, 3'b000, 3'b000, 0, 0);
        checks++; if (bus.spr_y[9:0] !== 10'd416) begin errors++; $display("FAIL jump_y got %0d want 416", bus.spr_y[9:0]); end
        checks++; if (bus.spr_x[9:0] !== 10'd0) begin errors++; $display("FAIL jump_x got %0d want 0", bus.spr_x[9:0]); end
        repeat (14) drive(1'b1, 3'b000, 3'b001, 0, 0);
        checks++; if (bus.spr_y[9:0] !== 10'd0) begin errors++; $display("FAIL jump_clamp_y got %0d want 0", bus.spr_y[9:0]); end
        checks++; if (bus.spr_x[9:0] !== 10'd0) begin errors++; $display("FAIL jump_clamp_x got %0d want 0", bus.spr_x[9:0]); end
        repeat (4) drive(1'b0, 3'b100, 3'b000, 0, 0);
        drive(1'b1, 3'b000, 3'b100, 0, 0);
        checks++; if (bus.spr_y[29:20] !== 10'd352) begin errors++; $display("FAIL jump_lvl0_y got %0d want 352", bus.spr_y[29:20]); end
        checks++; if (bus.spr_x[29:20] !== 10'd15) begin errors++; $display("FAIL jump_lvl0_x got %0d want 15", bus.spr_x[29:20]); end
        checks++; if (bus.spr_x[19:10] !== 10'(mx[1])) begin errors++; $display("FAIL jump_other_x got %0d want %0d", bus.spr_x[19:10], mx[1]); end
    endtask

    task automatic test_overlap();
        apply_reset();
        drive(1'b1, 3'b000, 3'b001, 0, 0);
        drive(1'b0, 3'b000, 3'b000, 10, 420);
        checks++; if (bus.hit_id !== 2'd0 || bus.hit_any !== 1'b1) begin errors++; $display("FAIL overlap_id got %0d/%0d want 1/0", bus.hit_any, bus.hit_id); end
        checks++; if (bus.rom_addr !== 16'd266) begin errors++; $display("FAIL overlap_addr got %0d want 266", bus.rom_addr); end
        drive(1'b0, 3'b000, 3'b000, 64, 420);
        checks++; if (bus.hit_id !== 2'd1) begin errors++; $display("FAIL overlap_edge_id got %0d want 1", bus.hit_id); end
        checks++; if (bus.rom_addr !== 16'd319) begin errors++; $display("FAIL overlap_edge_addr got %0d want 319", bus.rom_addr); end
    endtask

    task automatic test_random();
        int k, px, py;
        bit fs;
        logic [2:0] su, jp;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            fs = ($urandom_range(0, 1) == 0);
            for (int b = 0; b < 3; b++) begin
                su[b] = ($urandom_range(0, 29) == 0);
                jp[b] = ($urandom_range(0, 39) == 0);
            end
            k  = $urandom_range(0, 2);
            px = mx[k] + $urandom_range(0, 67) - 2;
            py = my[k] + $urandom_range(0, 35) - 2;
            if (px < 0) px = 0;
            if (py < 0) py = 0;
            if (px > 1023) px = 1023;
            if (py > 1023) py = 1023;
            drive(fs, su, jp, px, py);
            checks++; if (bus.hit_any !== 1'(e_hit) || bus.hit_id !== 2'(e_id) || bus.rom_addr !== 16'(e_addr)) begin
                errors++; $display("FAIL rnd_pixel cyc %0d got %0d/%0d/%0d want %0d/%0d/%0d", c, bus.hit_any, bus.hit_id, bus.rom_addr, e_hit, e_id, e_addr);
            end
            checks++; if (bus.anim_frame !== 3'((mc / 2) % 8)) begin errors++; $display("FAIL rnd_anim cyc %0d got %0d want %0d", c, bus.anim_frame, (mc / 2) % 8); end
            for (int i = 0; i < 3; i++) begin
                checks++; if (bus.spr_x[10*i +: 10] !== 10'(mx[i]) || bus.spr_y[10*i +: 10] !== 10'(my[i]) ||
                              bus.spr_dir[2*i +: 2] !== {1'(mdy[i]), 1'(mdx[i])} || bus.speed_lvl[3*i +: 3] !== 3'(ml[i])) begin
                    errors++; $display("FAIL rnd_state%0d cyc %0d got x%0d y%0d d%b l%0d want x%0d y%0d d%0d%0d l%0d", i, c,
                        bus.spr_x[10*i +: 10], bus.spr_y[10*i +: 10], bus.spr_dir[2*i +: 2], bus.speed_lvl[3*i +: 3],
                        mx[i], my[i], mdy[i], mdx[i], ml[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        repeat (3) drive(1'b1, 3'b011, 3'b000, 0, 0);
        drive(1'b0, 3'b000, 3'b000, 20, 450);
        checks++; if (bus.hit_any !== 1'b1) begin errors++; $display("FAIL midrst_pre_hit got %0d want 1", bus.hit_any); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.spr_x !== 30'd0) begin errors++; $display("FAIL midrst_x got %h want 0", bus.spr_x); end
        checks++; if (bus.spr_y !== {10'd384, 10'd416, 10'd448}) begin errors++; $display("FAIL midrst_y got %h want %h", bus.spr_y, {10'd384, 10'd416, 10'd448}); end
        checks++; if (bus.speed_lvl !== {3'd1, 3'd1, 3'd1} || bus.spr_dir !== 6'd0) begin errors++; $display("FAIL midrst_lvl_dir got %h/%h want 049/0", bus.speed_lvl, bus.spr_dir); end
        checks++; if (bus.hit_any !== 1'b0 || bus.hit_id !== 2'd0 || bus.rom_addr !== 16'd0 || bus.anim_frame !== 3'd0) begin
            errors++; $display("FAIL midrst_pixel got %0d/%0d/%0d/%0d want 0/0/0/0", bus.hit_any, bus.hit_id, bus.rom_addr, bus.anim_frame);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        drive(1'b1, 3'b000, 3'b000, 0, 0);
        checks++; if (bus.spr_x[9:0] !== 10'd1) begin errors++; $display("FAIL midrst_resume_x got %0d want 1", bus.spr_x[9:0]); end
    endtask

    initial begin
        reset_n = 1'b0;
        bus.frame_sync = 1'b0; bus.speed_up = '0; bus.jump = '0; bus.pixel_x = '0; bus.pixel_y = '0;
        model_reset();
        test_reset();
        test_bounce();
        test_mirror_anim();
        test_address();
        test_speed();
        test_jump();
        test_overlap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
